// File: rtl/cbuf_write_arbiter.sv
// Round-robin arbiter sharing one circular_buffer write port between two
// producers. Each grant lasts up to BURST accepted beats. Writes are throttled
// by buf_ready, and the port passes straight to the other requester on release.
module cbuf_write_arbiter #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned PAR_WRITE = 1,
    parameter int unsigned BURST     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0,
    input  logic [BITS*PAR_WRITE-1:0] din0,
    output logic                      ack0,
    input  logic                      req1,
    input  logic [BITS*PAR_WRITE-1:0] din1,
    output logic                      ack1,
    input  logic                      buf_ready,
    output logic                      buf_write_en,
    output logic [BITS*PAR_WRITE-1:0] buf_din,
    output logic [1:0]                grant,
    output logic                      busy
);

    localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             prio;
    logic             prio_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             own_req;
    logic             oth_req;
    logic             accept;

    // State, round-robin pointer and burst counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            prio  <= prio_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: arbitration in IDLE, burst counting and release while serving
    always_comb begin
        state_n = state;
        prio_n  = prio;
        cnt_n   = cnt;
        own_req = 1'b0;
        oth_req = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || !prio)) begin
                    state_n = SERVE0;
                end else if (req1) begin
                    state_n = SERVE1;
                end
            end
            SERVE0, SERVE1: begin
                own_req = (state == SERVE1) ? req1 : req0;
                oth_req = (state == SERVE1) ? req0 : req1;
                accept  = own_req & buf_ready;
                if (!own_req || (accept && (cnt == CNT_LAST))) begin
                    // Release: hand the port straight over if the other side waits
                    cnt_n  = '0;
                    prio_n = (state == SERVE0);
                    if (oth_req) begin
                        state_n = (state == SERVE0) ? SERVE1 : SERVE0;
                    end else if (own_req) begin
                        state_n = state;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (accept) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs follow the owner combinationally so a stall blocks the write in the same cycle
    always_comb begin
        grant        = 2'b00;
        busy         = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        buf_write_en = 1'b0;
        buf_din      = '0;
        case (state)
            SERVE0: begin
                grant        = 2'b01;
                busy         = 1'b1;
                ack0         = req0 & buf_ready;
                buf_write_en = req0 & buf_ready;
                buf_din      = din0;
            end
            SERVE1: begin
                grant        = 2'b10;
                busy         = 1'b1;
                ack1         = req1 & buf_ready;
                buf_write_en = req1 & buf_ready;
                buf_din      = din1;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

endmodule
